// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The optional macro IFQ_BRANCH_FOLD_EN uses branch_target() to fold unconditional B instructions.
package ifq_pkg;

  localparam logic [63:0] PC_STEP = 64'd4;
  localparam logic [5:0]  OPC_B   = 6'b000101;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } ifq_state_e;

  // B-format target: imm26 is a signed word offset from the branch's own PC
  function automatic logic [63:0] branch_target(input logic [63:0] pc, input logic [31:0] instr);
    return pc + {{36{instr[25]}}, instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_checker.sv
// Runtime property checks for the fetch queue; holds no design state.
module ifq_checker (
  input logic i_clk,
  input logic i_rst_n,
  input logic i_push,
  input logic i_pop,
  input logic i_full
);

  // The credit scheme must never let a response land in a full queue
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && i_full && !i_pop));

endmodule

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush; head is read combinationally.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  ifq_entry_t             i_data,
  output ifq_entry_t             o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);

  ifq_entry_t  r_mem [DEPTH];
  logic [PW:0] r_wptr;
  logic [PW:0] r_rptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign w_do_pop  = i_pop && !o_empty;
  // A full queue may still accept a write when the head leaves in the same cycle
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_count = r_wptr - r_rptr;
  assign o_full  = (o_count == (PW+1)'(DEPTH));
  assign o_empty = (o_count == (PW+1)'(0));
  assign o_head  = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= (PW+1)'(0);
      r_rptr <= (PW+1)'(0);
    end else if (i_flush) begin
      r_wptr <= (PW+1)'(0);
      r_rptr <= (PW+1)'(0);
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + (PW+1)'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wptr[PW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front-end: sequential PC generation, imem credit/discard tracking, decode-side queue.
// Optional macro IFQ_BRANCH_FOLD_EN folds LEGv8 B instructions into an internal redirect.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic [63:0] startpc,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [63:0] dec_pc
);

  localparam int CW = $clog2(DEPTH + MAX_OUTSTANDING + 1) + 1;

  ifq_state_e            r_state;
  logic [63:0]           r_fetch_pc;
  logic [63:0]           r_resp_pc;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_discard;

  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  ifq_entry_t             w_head;
  ifq_entry_t             w_push_data;

  logic          w_run;
  logic          w_redirect;
  logic          w_resp_fire;
  logic          w_drop;
  logic          w_fold;
  logic          w_req_allow;
  logic          w_req_fire;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_credit_used;
  logic [CW-1:0] w_inflight_next;

  assign w_run       = (r_state == RUN);
  assign w_redirect  = w_run && redirect;
  assign w_resp_fire = w_run && imem_resp_valid;
  assign w_drop      = w_resp_fire && (r_discard != CW'(0));

`ifdef IFQ_BRANCH_FOLD_EN
  logic [63:0] w_fold_target;
  assign w_fold        = w_resp_fire && !w_drop && !w_redirect && (imem_resp_data[31:26] == OPC_B);
  assign w_fold_target = branch_target(r_resp_pc, imem_resp_data);
`else
  assign w_fold = 1'b0;
`endif

  // Slots already promised: queued entries plus in-flight requests that will be kept
  assign w_credit_used = CW'(w_count) + r_outstanding - r_discard;
  assign w_req_allow   = w_run && !w_redirect && !w_fold &&
                         (r_outstanding < CW'(MAX_OUTSTANDING)) &&
                         (w_credit_used < CW'(DEPTH));
  assign w_req_fire      = w_req_allow && imem_req_ready;
  assign w_inflight_next = r_outstanding + CW'(w_req_fire) - CW'(w_resp_fire);

  assign w_push      = w_resp_fire && !w_drop && !w_redirect && !w_fold;
  assign w_pop       = dec_valid && dec_ready && !w_redirect;
  assign w_push_data = '{pc: r_resp_pc, instr: imem_resp_data};

  assign imem_req_valid = w_req_allow;
  assign imem_req_addr  = r_fetch_pc;

  always_comb begin
    dec_valid = !w_empty;
    if (w_empty) begin
      dec_instr = 32'd0;
      dec_pc    = 64'd0;
    end else begin
      dec_instr = w_head.instr;
      dec_pc    = w_head.pc;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= BOOT;
      r_fetch_pc    <= 64'd0;
      r_resp_pc     <= 64'd0;
      r_outstanding <= CW'(0);
      r_discard     <= CW'(0);
    end else begin
      case (r_state)
        BOOT: begin
          r_fetch_pc <= startpc;
          r_resp_pc  <= startpc;
          r_state    <= RUN;
        end
        RUN: begin
          r_outstanding <= w_inflight_next;
          if (w_redirect) begin
            r_fetch_pc <= redirect_pc;
            r_resp_pc  <= redirect_pc;
            r_discard  <= w_inflight_next;
`ifdef IFQ_BRANCH_FOLD_EN
          end else if (w_fold) begin
            r_fetch_pc <= w_fold_target;
            r_resp_pc  <= w_fold_target;
            r_discard  <= w_inflight_next;
`endif
          end else begin
            if (w_req_fire) begin
              r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            if (w_resp_fire) begin
              if (w_drop) begin
                r_discard <= r_discard - CW'(1);
              end else begin
                r_resp_pc <= r_resp_pc + PC_STEP;
              end
            end
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  ifq_checker u_checker (
    .i_clk   (CLK),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_full  (w_full)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized scoreboard bench for ifetch_queue: decode must see an unbroken +4 stream from the latest start/redirect PC.
module tb_ifetch_queue;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] startpc = 64'd0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;

  always #5 CLK = ~CLK;

  ifetch_queue #(
    .DEPTH(4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .CLK             (CLK),
    .reset_n         (reset_n),
    .startpc         (startpc),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  exp_t        sb_q[$];
  logic [63:0] mem_q[$];

  // Memory contents; opcode field never equals the B opcode
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {6'b110101, a[27:2]} ^ {6'd0, a[59:34]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Decode must see start, start+4, ... until the next redirect or reset
  task automatic expect_stream(input logic [63:0] start);
    logic [63:0] p;
    sb_q.delete();
    for (int i = 0; i < 64; i++) begin
      p = start + 64'(4 * i);
      sb_q.push_back('{pc: p, instr: mem_word(p)});
    end
  endtask

  // Imem model: record accepted request addresses in order
  always @(negedge CLK) begin
    if (reset_n && imem_req_valid && imem_req_ready) begin
      mem_q.push_back(imem_req_addr);
    end
  end

  // Monitor: every consumed head is compared against the scoreboard
  always @(negedge CLK) begin
    exp_t e;
    if (reset_n && !redirect && dec_valid && dec_ready) begin
      pops++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=%h required=none", dec_pc);
      end else begin
        e = sb_q.pop_front();
        check("dec_pc", dec_pc, e.pc);
        check("dec_instr", 64'(dec_instr), 64'(e.instr));
      end
    end
  end

  task automatic drive_cycle(input int rdy, input int dec, input int rsp,
                             input bit redir, input logic [63:0] rpc);
    @(posedge CLK);
    #1;
    if (mem_q.size() > 0 && int'($urandom_range(99)) < rsp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    imem_req_ready = (int'($urandom_range(99)) < rdy);
    dec_ready      = (int'($urandom_range(99)) < dec);
    redirect       = redir;
    redirect_pc    = redir ? rpc : {$urandom, $urandom};
    if (redir) expect_stream(rpc);
  endtask

  task automatic do_reset(input logic [63:0] spc, input bit boot_redir);
    @(posedge CLK);
    #1;
    reset_n         = 1'b0;
    redirect        = 1'b0;
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b1;
    dec_ready       = 1'b1;
    startpc         = spc;
    mem_q.delete();
    sb_q.delete();
    @(negedge CLK);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", imem_req_addr, 64'd0);
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_dec_instr", 64'(dec_instr), 64'd0);
    check("rst_dec_pc", dec_pc, 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    reset_n     = 1'b1;
    expect_stream(spc);
    redirect    = boot_redir;
    redirect_pc = {$urandom, $urandom} & ~64'd3;
    @(negedge CLK);
    check("boot_req_valid", 64'(imem_req_valid), 64'd0);
    @(posedge CLK);
    #1;
    redirect = 1'b0;
    @(negedge CLK);
    check("run_req_valid", 64'(imem_req_valid), 64'd1);
    check("run_req_addr", imem_req_addr, spc);
  endtask

  initial begin
    int p0;
    int since;
    bit r;

    // Boot and full-rate streaming with a single-cycle pipelined imem
    do_reset(64'h1000, 1'b0);
    p0 = pops;
    repeat (30) drive_cycle(100, 100, 100, 1'b0, 64'd0);
    check("throughput", 64'(pops - p0 >= 25), 64'd1);

    // Backpressure: queue fills to DEPTH and requests stop
    repeat (12) drive_cycle(100, 0, 100, 1'b0, 64'd0);
    @(negedge CLK);
    check("bp_req_valid", 64'(imem_req_valid), 64'd0);
    check("bp_dec_valid", 64'(dec_valid), 64'd1);
    p0 = pops;
    repeat (6) drive_cycle(0, 100, 0, 1'b0, 64'd0);
    check("bp_held_entries", 64'(pops - p0), 64'd4);
    repeat (10) drive_cycle(100, 100, 100, 1'b0, 64'd0);

    // Redirect with MAX_OUTSTANDING requests in flight and a same-cycle response
    do_reset(64'h1000, 1'b0);
    repeat (3) drive_cycle(100, 100, 0, 1'b0, 64'd0);
    @(negedge CLK);
    check("maxout_req_valid", 64'(imem_req_valid), 64'd0);
    check("maxout_req_addr", imem_req_addr, 64'h1008);
    drive_cycle(100, 100, 100, 1'b1, 64'h2000);
    @(negedge CLK);
    check("redir_req_valid", 64'(imem_req_valid), 64'd0);
    check("redir_flush", 64'(dec_valid), 64'd0);
    p0 = pops;
    repeat (15) drive_cycle(100, 100, 100, 1'b0, 64'd0);
    check("post_redir_progress", 64'(pops - p0 >= 5), 64'd1);

    // PC wrap, with a redirect held during BOOT that must be ignored
    do_reset(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    repeat (12) drive_cycle(100, 100, 100, 1'b0, 64'd0);

    // Randomized traffic with redirects and a mid-run reset
    do_reset({$urandom, $urandom} & ~64'd3, 1'b0);
    since = 0;
    for (int c = 0; c < 2400; c++) begin
      if (c == 1200) begin
        do_reset({$urandom, $urandom} & ~64'd3, 1'b0);
        since = 0;
      end
      r = (since >= 50) || ($urandom_range(99) < 6);
      drive_cycle(70, 70, 60, r, {$urandom, $urandom} & ~64'd3);
      since = r ? 0 : since + 1;
    end
    @(negedge CLK);
    check("total_progress", 64'(pops >= 500), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
